// File: rtl/mc6502_bus_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc6502_bus_if_pkg
//  Description : Shared state codes, R/W encodings and sizing helper for the
//                mc6502 bus interface unit.
//  Revision    : 1.0  initial release
// ============================================================================
package mc6502_bus_if_pkg;

    typedef enum logic [1:0] {
        C_BIU_IDLE   = 2'd0,
        C_BIU_ACCESS = 2'd1,
        C_BIU_HOLD   = 2'd2,
        C_BIU_DONE   = 2'd3
    } biu_state_t;

    localparam logic C_RW_READ  = 1'b1;
    localparam logic C_RW_WRITE = 1'b0;

    // A zero TIMEOUT still needs a 1-bit counter to keep the datapath legal.
    function automatic int biu_cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc6502_biu_wdog.sv
`default_nettype none
// ============================================================================
//  Module      : mc6502_biu_wdog
//  Description : ACCESS-state wait counter with saturating count and timeout
//                compare; expire is combinational on the last allowed cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module mc6502_biu_wdog
    import mc6502_bus_if_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expire
);

    localparam int                 c_cnt_w   = biu_cnt_width(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_max = '1;

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_run && (r_count != c_cnt_max)) begin
            r_count <= r_count + c_cnt_w'(1);
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT - 1);
            assign o_expire = i_run && (r_count == c_limit);
        end else begin : g_no_timeout
            assign o_expire = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mc6502_bus_if.sv
`default_nettype none
// ============================================================================
//  Module      : mc6502_bus_if
//  Description : mc6502 bus interface unit: latches core address/data, runs a
//                req/ack memory handshake with timeout, honours RDY on reads.
//                Optional counters enabled by MC6502_BIU_STATS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module mc6502_bus_if
    import mc6502_bus_if_pkg::*;
#(
    parameter int         TIMEOUT = 16,
    parameter logic [7:0] DB_INIT = 8'h00
) (
    input  logic        CLK,
    input  logic        RES_N,
    input  logic [7:0]  ABL,
    input  logic [7:0]  ABH,
    input  logic [7:0]  DB_OUT,
    input  logic        RW,
    input  logic        CYC_REQ,
    input  logic        RDY,
    input  logic        ERR_CLR,
    input  logic [7:0]  MEM_RDATA,
    input  logic        MEM_ACK,
    output logic [7:0]  DB_IN,
    output logic        CORE_RDY,
    output logic [15:0] MEM_ADDR,
    output logic [7:0]  MEM_WDATA,
    output logic        MEM_RE,
    output logic        MEM_WE,
`ifdef MC6502_BIU_STATS_EN
    output logic [15:0] RD_CNT,
    output logic [15:0] WR_CNT,
    output logic [15:0] STALL_CNT,
`endif
    output logic        BUS_ERR
);

    biu_state_t r_state;
    biu_state_t w_state_nxt;
    logic       r_rw;
    logic [7:0] r_hold_data;
    logic       w_start;
    logic       w_rd_done;
    logic       w_capture;
    logic       w_timeout_hit;
    logic       w_expire;
    logic       w_in_access;
    logic       w_leave_access;

    assign w_in_access    = (r_state == C_BIU_ACCESS);
    assign w_leave_access = w_in_access && (w_state_nxt != C_BIU_ACCESS);
    assign CORE_RDY       = (r_state == C_BIU_IDLE) || (r_state == C_BIU_DONE);

    mc6502_biu_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (CLK),
        .rst_n    (RES_N),
        .i_clear  (w_start),
        .i_run    (w_in_access),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_start       = 1'b0;
        w_rd_done     = 1'b0;
        w_capture     = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            C_BIU_IDLE: begin
                if (CYC_REQ) begin
                    w_start     = 1'b1;
                    w_state_nxt = C_BIU_ACCESS;
                end
            end
            C_BIU_ACCESS: begin
                // An acknowledge always beats a coincident timeout.
                if (MEM_ACK) begin
                    if (r_rw == C_RW_WRITE) begin
                        w_state_nxt = C_BIU_DONE;
                    end else if (RDY) begin
                        w_rd_done   = 1'b1;
                        w_state_nxt = C_BIU_DONE;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = C_BIU_HOLD;
                    end
                end else if (w_expire) begin
                    w_timeout_hit = 1'b1;
                    w_state_nxt   = C_BIU_DONE;
                end
            end
            C_BIU_HOLD: begin
                if (RDY) begin
                    w_rd_done   = 1'b1;
                    w_state_nxt = C_BIU_DONE;
                end
            end
            C_BIU_DONE: begin
                if (CYC_REQ) begin
                    w_start     = 1'b1;
                    w_state_nxt = C_BIU_ACCESS;
                end else begin
                    w_state_nxt = C_BIU_IDLE;
                end
            end
            default: w_state_nxt = C_BIU_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            r_state     <= C_BIU_IDLE;
            r_rw        <= C_RW_READ;
            r_hold_data <= '0;
            DB_IN       <= DB_INIT;
            MEM_ADDR    <= '0;
            MEM_WDATA   <= '0;
            MEM_RE      <= 1'b0;
            MEM_WE      <= 1'b0;
            BUS_ERR     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                MEM_ADDR  <= {ABH, ABL};
                MEM_WDATA <= DB_OUT;
                r_rw      <= RW;
                MEM_RE    <= (RW == C_RW_READ);
                MEM_WE    <= (RW == C_RW_WRITE);
            end else if (w_leave_access) begin
                MEM_RE <= 1'b0;
                MEM_WE <= 1'b0;
            end
            if (w_capture) begin
                r_hold_data <= MEM_RDATA;
            end
            if (w_rd_done) begin
                DB_IN <= (r_state == C_BIU_HOLD) ? r_hold_data : MEM_RDATA;
            end
            if (w_timeout_hit) begin
                BUS_ERR <= 1'b1;
            end else if (ERR_CLR) begin
                BUS_ERR <= 1'b0;
            end
        end
    end

`ifdef MC6502_BIU_STATS_EN
    logic w_wr_done;
    assign w_wr_done = w_in_access && MEM_ACK && (r_rw == C_RW_WRITE);

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            RD_CNT    <= '0;
            WR_CNT    <= '0;
            STALL_CNT <= '0;
        end else begin
            if (w_rd_done) RD_CNT    <= RD_CNT + 16'd1;
            if (w_wr_done) WR_CNT    <= WR_CNT + 16'd1;
            if (!CORE_RDY) STALL_CNT <= STALL_CNT + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc6502_bus_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc6502_bus_if
//  Description : Self-checking bench for mc6502_bus_if: directed vector table,
//                hand sequences and randomized transactions vs. a txn model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mc6502_bus_if;

    localparam int         c_timeout = 16;
    localparam logic [7:0] c_db_init = 8'hC3;

    logic        CLK = 1'b0;
    logic        RES_N = 1'b0;
    logic [7:0]  ABL = '0, ABH = '0, DB_OUT = '0, MEM_RDATA = '0;
    logic        RW = 1'b1, CYC_REQ = 1'b0, RDY = 1'b1, ERR_CLR = 1'b0, MEM_ACK = 1'b0;
    logic [7:0]  DB_IN, MEM_WDATA;
    logic [15:0] MEM_ADDR;
    logic        CORE_RDY, MEM_RE, MEM_WE, BUS_ERR;
`ifdef MC6502_BIU_STATS_EN
    logic [15:0] RD_CNT, WR_CNT, STALL_CNT;
`endif

    mc6502_bus_if #(
        .TIMEOUT (c_timeout),
        .DB_INIT (c_db_init)
    ) dut (
        .CLK       (CLK),
        .RES_N     (RES_N),
        .ABL       (ABL),
        .ABH       (ABH),
        .DB_OUT    (DB_OUT),
        .RW        (RW),
        .CYC_REQ   (CYC_REQ),
        .RDY       (RDY),
        .ERR_CLR   (ERR_CLR),
        .MEM_RDATA (MEM_RDATA),
        .MEM_ACK   (MEM_ACK),
        .DB_IN     (DB_IN),
        .CORE_RDY  (CORE_RDY),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .MEM_RE    (MEM_RE),
        .MEM_WE    (MEM_WE),
`ifdef MC6502_BIU_STATS_EN
        .RD_CNT    (RD_CNT),
        .WR_CNT    (WR_CNT),
        .STALL_CNT (STALL_CNT),
`endif
        .BUS_ERR   (BUS_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  wd;
        int          ack_at;     // ACCESS cycle carrying MEM_ACK, 0 = never
        logic [7:0]  rd;
        int          rdy_low;    // reads: HOLD cycles; writes: nonzero drives RDY=0
        logic        clr;        // ERR_CLR held through the transaction
        logic [7:0]  exp_db;
        logic        exp_err;
        int          exp_strobe;
        int          exp_stall;
    } vec_t;

    vec_t tbl [8];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [7:0] m_db;
    logic       m_err;
    int         m_rd, m_wr, m_stall;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic run_txn(input vec_t v, output int strobe, output int stall,
                           output logic [15:0] addr_o, output logic [7:0] wd_o,
                           output logic re_o, output logic we_o, output logic db_early);
        logic [7:0] db0;
        logic       acked;
        int         h;
        db0 = DB_IN; acked = 1'b0; h = 0; strobe = 0; stall = 0; db_early = 1'b0;
        {ABH, ABL} = v.addr; DB_OUT = v.wd; RW = v.rw; CYC_REQ = 1'b1;
        ERR_CLR = v.clr; MEM_ACK = 1'b0;
        RDY = v.rw ? 1'b1 : (v.rdy_low == 0);
        tick;
        CYC_REQ = 1'b0; {ABH, ABL} = ~v.addr; DB_OUT = ~v.wd; RW = ~v.rw;
        addr_o = MEM_ADDR; wd_o = MEM_WDATA; re_o = MEM_RE; we_o = MEM_WE;
        while (!CORE_RDY && stall < 100) begin
            if (MEM_RE || MEM_WE) strobe++;
            if (DB_IN !== db0) db_early = 1'b1;
            stall++;
            if (!acked) begin
                MEM_ACK   = (stall == v.ack_at);
                MEM_RDATA = MEM_ACK ? v.rd : 8'($urandom);
                if (!v.rw)        RDY = (v.rdy_low == 0);
                else if (MEM_ACK) RDY = (v.rdy_low == 0);
                else              RDY = 1'($urandom_range(0, 1));
                acked = MEM_ACK;
            end else begin
                MEM_ACK = 1'b0;
                h++;
                RDY = (h >= v.rdy_low);
                MEM_RDATA = 8'($urandom);
            end
            tick;
        end
        MEM_ACK = 1'b0; ERR_CLR = 1'b0; RDY = 1'b1;
    endtask

    task automatic check_txn(input string tag, input vec_t v);
        int          strobe, stall;
        logic [15:0] addr_o;
        logic [7:0]  wd_o;
        logic        re_o, we_o, db_early;
        run_txn(v, strobe, stall, addr_o, wd_o, re_o, we_o, db_early);
        chk($sformatf("%s_addr", tag),     32'(addr_o), 32'(v.addr));
        chk($sformatf("%s_wdata", tag),    32'(wd_o), 32'(v.wd));
        chk($sformatf("%s_re", tag),       32'(re_o), 32'(v.rw));
        chk($sformatf("%s_we", tag),       32'(we_o), 32'(!v.rw));
        chk($sformatf("%s_strobe", tag),   32'(strobe), 32'(v.exp_strobe));
        chk($sformatf("%s_stall", tag),    32'(stall), 32'(v.exp_stall));
        chk($sformatf("%s_db_in", tag),    32'(DB_IN), 32'(v.exp_db));
        chk($sformatf("%s_bus_err", tag),  32'(BUS_ERR), 32'(v.exp_err));
        chk($sformatf("%s_db_early", tag), 32'(db_early), 32'd0);
        chk($sformatf("%s_strb_off", tag), 32'(MEM_RE | MEM_WE), 32'd0);
    endtask

    // Transaction-level model: outcome depends only on ack position vs. the budget.
    function automatic vec_t model_txn(input vec_t v);
        vec_t r;
        logic to;
        r  = v;
        to = (v.ack_at == 0) || (v.ack_at > c_timeout);
        r.exp_strobe = to ? c_timeout : v.ack_at;
        r.exp_stall  = r.exp_strobe + ((v.rw && !to) ? v.rdy_low : 0);
        if (v.rw && !to) m_db = v.rd;
        if (to)         m_err = 1'b1;
        else if (v.clr) m_err = 1'b0;
        m_rd    += (v.rw && !to) ? 1 : 0;
        m_wr    += (!v.rw && !to) ? 1 : 0;
        m_stall += r.exp_stall;
        r.exp_db  = m_db;
        r.exp_err = m_err;
        return r;
    endfunction

    function automatic vec_t rand_vec(input logic rw);
        vec_t v;
        v.rw = rw; v.addr = 16'($urandom); v.wd = 8'($urandom);
        v.ack_at = $urandom_range(0, 20); v.rd = 8'($urandom);
        v.rdy_low = $urandom_range(0, 3); v.clr = 1'($urandom_range(0, 1));
        v.exp_db = '0; v.exp_err = 1'b0; v.exp_strobe = 0; v.exp_stall = 0;
        return v;
    endfunction

    initial begin
        //          rw    addr      wd     ack rd     rlow clr   db     err   strb stall
        tbl[0] = '{1'b1, 16'h1234, 8'h00, 3,  8'hA5, 0,   1'b0, 8'hA5, 1'b0, 3,   3};
        tbl[1] = '{1'b0, 16'h0200, 8'h5A, 2,  8'h00, 1,   1'b0, 8'hA5, 1'b0, 2,   2};
        tbl[2] = '{1'b1, 16'hFFFE, 8'h11, 0,  8'hEE, 0,   1'b0, 8'hA5, 1'b1, 16,  16};
        tbl[3] = '{1'b1, 16'h00FF, 8'h22, 3,  8'h3C, 4,   1'b1, 8'h3C, 1'b0, 3,   7};
        tbl[4] = '{1'b1, 16'h8000, 8'h33, 16, 8'h77, 0,   1'b0, 8'h77, 1'b0, 16,  16};
        tbl[5] = '{1'b0, 16'h1357, 8'h99, 1,  8'h00, 0,   1'b0, 8'h77, 1'b0, 1,   1};
        tbl[6] = '{1'b1, 16'h0001, 8'h44, 1,  8'h00, 1,   1'b0, 8'h00, 1'b0, 1,   2};
        tbl[7] = '{1'b0, 16'h2468, 8'h55, 0,  8'h00, 0,   1'b1, 8'h00, 1'b1, 16,  16};

        repeat (3) @(posedge CLK);
        @(negedge CLK) RES_N = 1'b1;
        tick;
        chk("rst_db_in",    32'(DB_IN), 32'(c_db_init));
        chk("rst_core_rdy", 32'(CORE_RDY), 32'd1);
        chk("rst_addr",     32'(MEM_ADDR), 32'd0);
        chk("rst_wdata",    32'(MEM_WDATA), 32'd0);
        chk("rst_strobes",  32'({MEM_RE, MEM_WE}), 32'd0);
        chk("rst_bus_err",  32'(BUS_ERR), 32'd0);

        MEM_ACK = 1'b1; MEM_RDATA = 8'h66;
        tick; tick;
        MEM_ACK = 1'b0;
        chk("idle_ack_db_in",    32'(DB_IN), 32'(c_db_init));
        chk("idle_ack_core_rdy", 32'(CORE_RDY), 32'd1);

        for (int i = 0; i < 8; i++) check_txn($sformatf("vec%0d", i), tbl[i]);

        ERR_CLR = 1'b1;
        tick;
        ERR_CLR = 1'b0;
        chk("err_clr_bus_err", 32'(BUS_ERR), 32'd0);
        chk("err_clr_db_in",   32'(DB_IN), 32'h00);

        m_db = 8'h00; m_err = 1'b0; m_rd = 0; m_wr = 0; m_stall = 0;
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                MEM_ACK = 1'($urandom_range(0, 1)); MEM_RDATA = 8'($urandom);
                tick;
            end
            MEM_ACK = 1'b0;
            if (gap > 0) chk($sformatf("rnd%0d_gap_db", i), 32'(DB_IN), 32'(m_db));
            check_txn($sformatf("rnd%0d", i), model_txn(rand_vec(1'($urandom_range(0, 1)))));
        end

        {ABH, ABL} = 16'h4321; RW = 1'b1; CYC_REQ = 1'b1;
        tick;
        CYC_REQ = 1'b0;
        tick;
        chk("midrst_re_before", 32'(MEM_RE), 32'd1);
        #2 RES_N = 1'b0;
        #1;
        chk("midrst_re",       32'(MEM_RE), 32'd0);
        chk("midrst_core_rdy", 32'(CORE_RDY), 32'd1);
        chk("midrst_db_in",    32'(DB_IN), 32'(c_db_init));
        chk("midrst_addr",     32'(MEM_ADDR), 32'd0);
        chk("midrst_bus_err",  32'(BUS_ERR), 32'd0);
        @(negedge CLK) RES_N = 1'b1;
        tick;

        m_db = c_db_init; m_err = 1'b0; m_rd = 0; m_wr = 0; m_stall = 0;
        for (int i = 0; i < 5; i++) begin
            vec_t v;
            v = rand_vec(i < 3);
            v.ack_at = $urandom_range(1, 5); v.clr = 1'b0;
            check_txn($sformatf("cnt%0d", i), model_txn(v));
        end
`ifdef MC6502_BIU_STATS_EN
        chk("stats_rd_cnt",    32'(RD_CNT), 32'(m_rd));
        chk("stats_wr_cnt",    32'(WR_CNT), 32'(m_wr));
        chk("stats_stall_cnt", 32'(STALL_CNT), 32'(m_stall));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
